plcounter: RTL and testbench

//   Preloadable up/down binary counter, WIDTH bits, wrap-around.
//   On leaving reset it preloads the parallel input `in`, then counts by one per clock.

---
 rtl/plcounter_pkg.sv | 14 +
 rtl/plcounter_step.sv | 31 +++
 rtl/plcounter.sv | 49 ++++
 tb/tb_plcounter.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/plcounter_pkg.sv
// Shared constants for the preloadable up/down counter.
// Latency: n/a (types and constants only).
// Backpressure: n/a (no handshake anywhere in this block).
package plcounter_pkg;

    // Encoding of the updown input.
    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/plcounter_step.sv
// Combinational +1/-1 unit: result = value + 1 when counting up, value - 1 when down, modulo 2^WIDTH.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
//
// Ports:
//   value   current counter value
//   updown  1 = increment, 0 = decrement
//   result  value +/- 1, wrapping at both ends
module plcounter_step
    import plcounter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] value,
    input  logic             updown,
    output logic [WIDTH-1:0] result
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    // Both directions are plain modular add/sub; the truncation to WIDTH bits is the wrap.
    always_comb begin
        result = value;
        if (dir_e'(updown) == DIR_UP) begin
            result = value + ONE;
        end else begin
            result = value - ONE;
        end
    end

endmodule

// File: rtl/plcounter.sv
// Preloadable free-running up/down counter: loads `in` on the first edge after reset, then counts each clock.
// Latency: out is registered; an updown change shows on the next rising edge.
// Backpressure: none; the counter never stalls once loaded.
//
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous reset, active-low (0 = in reset)
//   updown  count direction: 1 = up, 0 = down
//   in      preload value, sampled only on the first edge after reset release
//   out     registered counter value
module plcounter
    import plcounter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             updown,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);

    logic             load_pend;
    logic [WIDTH-1:0] step_val;

    plcounter_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .value  (out),
        .updown (updown),
        .result (step_val)
    );

    // load_pend re-arms on every reset so the first edge after release is always a
    // preload rather than a count. An edge coinciding with release still sees rst low
    // through the async path, which pushes the preload to the following edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out       <= '0;
            load_pend <= 1'b1;
        end else if (load_pend) begin
            out       <= in;
            load_pend <= 1'b0;
        end else begin
            out       <= step_val;
        end
    end

endmodule

// File: tb/tb_plcounter.sv
module tb_plcounter;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             updown;
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] out;

    plcounter #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .updown (updown),
        .in     (in),
        .out    (out)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // One directed vector. Sync vectors are applied at the falling edge and their
    // expectation is checked just after the following rising edge. Async vectors are
    // applied mid high-phase (no clock edge involved) and checked 1 time unit later.
    typedef struct {
        bit               is_async;
        logic             v_rst;
        logic             v_updown;
        logic [WIDTH-1:0] v_in;
        logic [WIDTH-1:0] v_exp;
        string            name;
    } vec_t;

    vec_t             vecs[$];
    logic [WIDTH-1:0] exp_q[$];
    string            name_q[$];
    event             async_ev;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void add_s(logic r, logic ud, logic [WIDTH-1:0] i,
                                  logic [WIDTH-1:0] e, string nm);
        vec_t v;
        v.is_async = 1'b0; v.v_rst = r; v.v_updown = ud; v.v_in = i; v.v_exp = e; v.name = nm;
        vecs.push_back(v);
    endfunction

    function automatic void add_a(logic r, logic ud, logic [WIDTH-1:0] i,
                                  logic [WIDTH-1:0] e, string nm);
        vec_t v;
        v.is_async = 1'b1; v.v_rst = r; v.v_updown = ud; v.v_in = i; v.v_exp = e; v.name = nm;
        vecs.push_back(v);
    endfunction

    // Monitor: whenever the DUT output is due (after a rising edge, or after an
    // asynchronous stimulus), pop the oldest expectation and compare.
    initial begin
        forever begin
            @(posedge clk or async_ev);
            #1;
            if (exp_q.size() > 0) begin
                logic [WIDTH-1:0] e;
                string            nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                n_checks++;
                if (out !== e) begin
                    n_fail++;
                    $display("FAIL %s: out=%0d expected=%0d at t=%0t", nm, out, e, $time);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d checks pending", exp_q.size());
        $fatal(1, "watchdog expired");
    end

    initial begin
        // 1. held in reset for three edges with in=0; out must be 0 between and on edges
        add_a(0, 0, 8'd0,   8'd0,   "rst_async_initial");
        add_s(0, 0, 8'd0,   8'd0,   "rst_hold_e1");
        add_a(0, 1, 8'd55,  8'd0,   "rst_hold_mid1");
        add_s(0, 0, 8'd0,   8'd0,   "rst_hold_e2");
        add_a(0, 0, 8'd0,   8'd0,   "rst_hold_mid2");
        add_s(0, 0, 8'd0,   8'd0,   "rst_hold_e3");
        // 2. release, preload 0, count down through the wrap
        add_s(1, 0, 8'd0,   8'd0,   "preload_0");
        add_s(1, 0, 8'd0,   8'd255, "down_wrap_255");
        add_s(1, 0, 8'd0,   8'd254, "down_254");
        // 3. reset pulse, preload 127, count up
        add_s(0, 1, 8'd127, 8'd0,   "rst_pulse_clear");
        add_a(0, 1, 8'd127, 8'd0,   "rst_pulse_mid");
        add_s(1, 1, 8'd127, 8'd127, "preload_127");
        add_s(1, 1, 8'd127, 8'd128, "up_128");
        add_s(1, 1, 8'd127, 8'd129, "up_129");
        // 4. preload 253 (updown=0 on the load edge is ignored), count up through the wrap
        add_s(0, 1, 8'd253, 8'd0,   "rst_before_253");
        add_s(1, 0, 8'd253, 8'd253, "preload_253_ud_ignored");
        add_s(1, 1, 8'd253, 8'd254, "up_254");
        add_s(1, 1, 8'd253, 8'd255, "up_255");
        add_s(1, 1, 8'd253, 8'd0,   "up_wrap_0");
        add_s(1, 1, 8'd253, 8'd1,   "up_1");
        // 5. reach 10, then reverse; in changes every 5 cycles without effect
        add_s(0, 1, 8'd8,   8'd0,   "rst_before_8");
        add_s(1, 1, 8'd8,   8'd8,   "preload_8");
        add_s(1, 1, 8'd8,   8'd9,   "up_9");
        add_s(1, 1, 8'd8,   8'd10,  "up_10");
        add_s(1, 0, 8'd8,   8'd9,   "dir_down_9");
        add_s(1, 0, 8'd8,   8'd8,   "dir_down_8");
        add_s(1, 0, 8'd99,  8'd7,   "in_ignored_7");
        add_s(1, 0, 8'd99,  8'd6,   "in_ignored_6");
        add_s(1, 0, 8'd99,  8'd5,   "in_ignored_5");
        add_s(1, 0, 8'd99,  8'd4,   "in_ignored_4");
        add_s(1, 0, 8'd99,  8'd3,   "in_ignored_3");
        add_s(1, 1, 8'd42,  8'd4,   "in_ignored_up_4");
        add_s(1, 1, 8'd42,  8'd5,   "in_ignored_up_5");
        add_s(1, 1, 8'd42,  8'd6,   "in_ignored_up_6");
        // 6. reach 200, assert reset between edges, reload from the current in
        add_s(0, 1, 8'd198, 8'd0,   "rst_before_198");
        add_s(1, 1, 8'd198, 8'd198, "preload_198");
        add_s(1, 1, 8'd198, 8'd199, "up_199");
        add_s(1, 1, 8'd198, 8'd200, "up_200");
        add_a(0, 1, 8'd198, 8'd0,   "midcount_async_clear");
        add_s(0, 1, 8'd77,  8'd0,   "midcount_rst_hold");
        add_s(1, 0, 8'd77,  8'd77,  "reload_current_in_77");
        add_s(1, 0, 8'd77,  8'd76,  "down_76");

        rst    = 1'b1;
        updown = 1'b0;
        in     = '0;
        #2;
        rst    = 1'b0;

        foreach (vecs[k]) begin
            if (vecs[k].is_async) begin
                // Lands between edges: after the previous edge's check, before the next fall.
                @(posedge clk);
                #5;
                rst    = vecs[k].v_rst;
                updown = vecs[k].v_updown;
                in     = vecs[k].v_in;
                exp_q.push_back(vecs[k].v_exp);
                name_q.push_back(vecs[k].name);
                ->async_ev;
            end else begin
                @(negedge clk);
                rst    = vecs[k].v_rst;
                updown = vecs[k].v_updown;
                in     = vecs[k].v_in;
                exp_q.push_back(vecs[k].v_exp);
                name_q.push_back(vecs[k].name);
            end
        end

        @(posedge clk);
        #3;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations unchecked, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
